llsc_reservation_ctrl: RTL and testbench

LL/SC reservation controller in the MEM stage. It owns the reservation state (valid flag plus granule address) and decides SC success in the same cycle. It drives a one-cycle write to the architectural LLbit register in WB. An optional snoop port lets a second bus master (DMA) break the reservation.

---
 rtl/llsc_reservation_ctrl_if.sv | 34 +++
 rtl/llsc_reservation_ctrl.sv | 122 ++++++++++++
 tb/tb_llsc_reservation_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/llsc_reservation_ctrl_if.sv
// Bus bundle between the MEM stage and the LL/SC reservation controller.
// master: pipeline side (drives instruction/snoop info, reads results).
// slave : reservation controller.
interface llsc_reservation_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              flush;
  logic              stall;
  logic              mem_valid;
  logic              mem_op_ll;
  logic              mem_op_sc;
  logic              mem_op_store;
  logic [ADDR_W-1:0] mem_addr;
  logic              eret;
  logic              snoop_we;
  logic [ADDR_W-1:0] snoop_addr;
  logic              sc_success;
  logic              llbit_o;
  logic              wb_llbit_we;
  logic              wb_llbit_wdata;
  logic [15:0]       sc_fail_cnt;

  modport master (
    output flush, stall, mem_valid, mem_op_ll, mem_op_sc, mem_op_store,
           mem_addr, eret, snoop_we, snoop_addr,
    input  sc_success, llbit_o, wb_llbit_we, wb_llbit_wdata, sc_fail_cnt
  );

  modport slave (
    input  flush, stall, mem_valid, mem_op_ll, mem_op_sc, mem_op_store,
           mem_addr, eret, snoop_we, snoop_addr,
    output sc_success, llbit_o, wb_llbit_we, wb_llbit_wdata, sc_fail_cnt
  );
endinterface

// File: rtl/llsc_reservation_ctrl.sv
// LL/SC reservation controller (MEM stage).
// Holds the reservation (valid + granule address), decides SC success
// combinationally, and issues a one-cycle LLbit write toward WB.
// Optional feature macro: LLSC_SNOOP_EN -- when defined, external (DMA)
// writes that hit the reserved granule break the reservation.
module llsc_reservation_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int GRANULE_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  llsc_reservation_ctrl_if.slave bus
);

  localparam int TAG_W = ADDR_W - GRANULE_LOG2;

  typedef enum logic {
    IDLE     = 1'b0,
    RESERVED = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [TAG_W-1:0]   res_addr_q, res_addr_d;
  logic               wb_we_q, wb_we_d;
  logic               wb_wdata_q, wb_wdata_d;
  logic [15:0]        fail_cnt_q, fail_cnt_d;

  logic [TAG_W-1:0]   mem_tag;
  logic               consumed;
  logic               addr_match;
  logic               snoop_kill;
  logic               sc_ok;

  // Saturating increment for the failed-SC counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign mem_tag    = bus.mem_addr[ADDR_W-1:GRANULE_LOG2];
  assign consumed   = bus.mem_valid & ~bus.stall & ~bus.flush;
  assign addr_match = (mem_tag == res_addr_q);

`ifdef LLSC_SNOOP_EN
  logic unused_low_bits;
  assign unused_low_bits = ^{bus.mem_addr[GRANULE_LOG2-1:0],
                             bus.snoop_addr[GRANULE_LOG2-1:0]};
  // An external write to the reserved granule kills the reservation.
  assign snoop_kill = bus.snoop_we & (state_q == RESERVED) &
                      (bus.snoop_addr[ADDR_W-1:GRANULE_LOG2] == res_addr_q);
`else
  logic unused_low_bits;
  assign unused_low_bits = ^{bus.mem_addr[GRANULE_LOG2-1:0],
                             bus.snoop_we, bus.snoop_addr};
  assign snoop_kill = 1'b0;
`endif

  // SC outcome is decided in the same cycle; stall does not mask it.
  assign sc_ok = bus.mem_valid & bus.mem_op_sc & ~bus.flush &
                 (state_q == RESERVED) & addr_match & ~snoop_kill;

  assign bus.sc_success     = sc_ok;
  assign bus.llbit_o        = (state_q == RESERVED);
  assign bus.wb_llbit_we    = wb_we_q;
  assign bus.wb_llbit_wdata = wb_wdata_q;
  assign bus.sc_fail_cnt    = fail_cnt_q;

  // Next-state, reservation address, WB pulse and fail counter.
  always_comb begin
    state_d    = state_q;
    res_addr_d = res_addr_q;
    wb_we_d    = 1'b0;
    wb_wdata_d = 1'b0;
    fail_cnt_d = fail_cnt_q;

    // Failed-SC accounting is independent of the reservation priority chain.
    if (consumed && bus.mem_op_sc && !sc_ok) begin
      fail_cnt_d = sat_inc16(fail_cnt_q);
    end

    if (bus.flush) begin
      // LLbit register clears itself on flush, so no WB write here.
      state_d = IDLE;
    end else if (bus.eret) begin
      state_d = IDLE;
      wb_we_d = 1'b1;
    end else if (consumed && bus.mem_op_ll) begin
      // The LL reservation is taken after any same-cycle snoop, so it wins.
      state_d    = RESERVED;
      res_addr_d = mem_tag;
      wb_we_d    = 1'b1;
      wb_wdata_d = 1'b1;
    end else if (snoop_kill) begin
      state_d = IDLE;
      wb_we_d = 1'b1;
    end else if (consumed && bus.mem_op_sc) begin
      state_d = IDLE;
      wb_we_d = 1'b1;
    end else if (consumed && bus.mem_op_store &&
                 (state_q == RESERVED) && addr_match) begin
      state_d = IDLE;
      wb_we_d = 1'b1;
    end
  end

  // State and output registers; reset returns everything to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      res_addr_q <= '0;
      wb_we_q    <= 1'b0;
      wb_wdata_q <= 1'b0;
      fail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      res_addr_q <= res_addr_d;
      wb_we_q    <= wb_we_d;
      wb_wdata_q <= wb_wdata_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

endmodule

// File: tb/tb_llsc_reservation_ctrl.sv
// Scoreboard bench for llsc_reservation_ctrl: stimulus pushes expected
// SC outcomes and WB LLbit writes into queues; a monitor on the falling
// edge pops and compares whenever the DUT presents an SC or a WB pulse.
module tb_llsc_reservation_ctrl;

  logic clk;
  logic rst;

  llsc_reservation_ctrl_if #(.ADDR_W(32)) bus ();

  llsc_reservation_ctrl #(.ADDR_W(32), .GRANULE_LOG2(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic sc_q[$];
  logic wb_q[$];
  logic [15:0] exp_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.flush        = 1'b0;
    bus.stall        = 1'b0;
    bus.mem_valid    = 1'b0;
    bus.mem_op_ll    = 1'b0;
    bus.mem_op_sc    = 1'b0;
    bus.mem_op_store = 1'b0;
    bus.mem_addr     = '0;
    bus.eret         = 1'b0;
    bus.snoop_we     = 1'b0;
    bus.snoop_addr   = '0;
  endtask

  task automatic op(input logic ll, input logic sc, input logic st, input logic [31:0] a);
    idle_in();
    bus.mem_valid    = 1'b1;
    bus.mem_op_ll    = ll;
    bus.mem_op_sc    = sc;
    bus.mem_op_store = st;
    bus.mem_addr     = a;
  endtask

  // Monitor: compare SC decisions and WB pulses against the queues.
  always @(negedge clk) begin
    assert (!(bus.mem_valid &&
              ($countones({bus.mem_op_ll, bus.mem_op_sc, bus.mem_op_store}) > 1)))
      else $error("illegal op encoding: more than one op bit set");
    if (!rst && bus.mem_valid && bus.mem_op_sc) begin
      if (sc_q.size() == 0) begin
        check("sc_unexpected", 32'd1, 32'd0);
      end else begin
        check("sc_success", {31'd0, bus.sc_success}, {31'd0, sc_q.pop_front()});
      end
    end
    if (bus.wb_llbit_we) begin
      if (wb_q.size() == 0) begin
        check("wb_unexpected_pulse", 32'd1, 32'd0);
      end else begin
        check("wb_wdata", {31'd0, bus.wb_llbit_wdata}, {31'd0, wb_q.pop_front()});
      end
    end
  end

  initial begin
    idle_in();
    rst = 1'b1;
    exp_cnt = 16'd0;
    cyc();
    cyc();
    check("rst_llbit", {31'd0, bus.llbit_o}, 32'd0);
    check("rst_wb_we", {31'd0, bus.wb_llbit_we}, 32'd0);
    check("rst_cnt", {16'd0, bus.sc_fail_cnt}, 32'd0);
    check("rst_sc", {31'd0, bus.sc_success}, 32'd0);
    rst = 1'b0;

    // LL then SC to same address: success.
    op(1, 0, 0, 32'h1000); wb_q.push_back(1'b1); cyc();
    check("ll1_llbit", {31'd0, bus.llbit_o}, 32'd1);
    op(0, 1, 0, 32'h1000); sc_q.push_back(1'b1); wb_q.push_back(1'b0); cyc();
    check("sc1_llbit", {31'd0, bus.llbit_o}, 32'd0);
    check("sc1_cnt", {16'd0, bus.sc_fail_cnt}, {16'd0, exp_cnt});
    idle_in(); cyc();

    // SC to different granule fails.
    op(1, 0, 0, 32'h1000); wb_q.push_back(1'b1); cyc();
    op(0, 1, 0, 32'h1004); sc_q.push_back(1'b0); wb_q.push_back(1'b0); cyc();
    exp_cnt = 16'd1;
    check("sc2_cnt", {16'd0, bus.sc_fail_cnt}, {16'd0, exp_cnt});
    check("sc2_llbit", {31'd0, bus.llbit_o}, 32'd0);

    // Store to same granule breaks reservation.
    op(1, 0, 0, 32'h2000); wb_q.push_back(1'b1); cyc();
    op(0, 0, 1, 32'h2002); wb_q.push_back(1'b0); cyc();
    check("st_llbit", {31'd0, bus.llbit_o}, 32'd0);
    op(0, 1, 0, 32'h2000); sc_q.push_back(1'b0); wb_q.push_back(1'b0); cyc();
    exp_cnt = 16'd2;
    check("sc3_cnt", {16'd0, bus.sc_fail_cnt}, {16'd0, exp_cnt});

    // Flush with SC in MEM: no WB pulse, reservation gone, no count.
    op(1, 0, 0, 32'h3000); wb_q.push_back(1'b1); cyc();
    op(0, 1, 0, 32'h3000); bus.flush = 1'b1; sc_q.push_back(1'b0); cyc();
    check("flush_llbit", {31'd0, bus.llbit_o}, 32'd0);
    check("flush_cnt", {16'd0, bus.sc_fail_cnt}, {16'd0, exp_cnt});
    op(0, 1, 0, 32'h3000); sc_q.push_back(1'b0); wb_q.push_back(1'b0); cyc();
    exp_cnt = 16'd3;
    check("reissue_cnt", {16'd0, bus.sc_fail_cnt}, {16'd0, exp_cnt});

    // Stall: no state change, no pulse; sc_success still evaluated.
    op(1, 0, 0, 32'h5000); bus.stall = 1'b1; cyc();
    check("stall_ll_llbit", {31'd0, bus.llbit_o}, 32'd0);
    op(1, 0, 0, 32'h5000); wb_q.push_back(1'b1); cyc();
    op(0, 1, 0, 32'h5000); bus.stall = 1'b1; sc_q.push_back(1'b1); cyc();
    check("stall_sc_llbit", {31'd0, bus.llbit_o}, 32'd1);
    op(0, 1, 0, 32'h5000); sc_q.push_back(1'b1); wb_q.push_back(1'b0); cyc();
    check("unstall_sc_llbit", {31'd0, bus.llbit_o}, 32'd0);
    check("unstall_sc_cnt", {16'd0, bus.sc_fail_cnt}, {16'd0, exp_cnt});

    // ERET breaks the reservation and writes 0.
    op(1, 0, 0, 32'h6000); wb_q.push_back(1'b1); cyc();
    idle_in(); bus.eret = 1'b1; wb_q.push_back(1'b0); cyc();
    check("eret_llbit", {31'd0, bus.llbit_o}, 32'd0);

    // Snoop in the same cycle as the SC.
    op(1, 0, 0, 32'h4000); wb_q.push_back(1'b1); cyc();
    op(0, 1, 0, 32'h4000); bus.snoop_we = 1'b1; bus.snoop_addr = 32'h4000;
`ifdef LLSC_SNOOP_EN
    sc_q.push_back(1'b0); exp_cnt = exp_cnt + 16'd1;
`else
    sc_q.push_back(1'b1);
`endif
    wb_q.push_back(1'b0); cyc();
    check("snoop_sc_cnt", {16'd0, bus.sc_fail_cnt}, {16'd0, exp_cnt});

    // Standalone snoop to the reserved granule.
    op(1, 0, 0, 32'h7000); wb_q.push_back(1'b1); cyc();
    idle_in(); bus.snoop_we = 1'b1; bus.snoop_addr = 32'h7001;
`ifdef LLSC_SNOOP_EN
    wb_q.push_back(1'b0); cyc();
    check("snoop_llbit", {31'd0, bus.llbit_o}, 32'd0);
`else
    cyc();
    check("snoop_llbit", {31'd0, bus.llbit_o}, 32'd1);
`endif
    idle_in(); bus.eret = 1'b1; wb_q.push_back(1'b0); cyc();
    check("eret2_llbit", {31'd0, bus.llbit_o}, 32'd0);

    // 65537 failed SCs: counter saturates.
    for (int i = 0; i < 65537; i++) begin
      op(0, 1, 0, 32'h8000); sc_q.push_back(1'b0); wb_q.push_back(1'b0); cyc();
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end
    check("sat_cnt", {16'd0, bus.sc_fail_cnt}, 32'h0000FFFF);
    check("sat_model", {16'd0, bus.sc_fail_cnt}, {16'd0, exp_cnt});

    // Reset while reserved: everything back to zero.
    op(1, 0, 0, 32'h9000); wb_q.push_back(1'b1); cyc();
    check("pre_rst_llbit", {31'd0, bus.llbit_o}, 32'd1);
    idle_in(); rst = 1'b1; cyc();
    check("mid_rst_llbit", {31'd0, bus.llbit_o}, 32'd0);
    check("mid_rst_wb_we", {31'd0, bus.wb_llbit_we}, 32'd0);
    check("mid_rst_cnt", {16'd0, bus.sc_fail_cnt}, 32'd0);
    rst = 1'b0;
    cyc();
    cyc();

    check("sc_queue_drained", sc_q.size(), 32'd0);
    check("wb_queue_drained", wb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
